// File: rtl/qpsk_symbol_sequencer.sv
// Byte-to-QPSK-symbol burst sequencer: takes bytes over valid/ready, emits four
// 2-bit symbols per byte (MSB pair first), each held for a programmable length.
module qpsk_symbol_sequencer #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] symbol_len,
  input  logic [CNT_W-1:0] n_bytes,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [1:0]       TX,
  output logic             tx_en,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       sym_q, sym_d;
  logic [5:0]       shift_q, shift_d;
  logic [7:0]       buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [1:0]       tx_d;
  logic             tx_en_d, busy_d, done_d, underrun_d, ready_d;
  logic             xfer_c;

  assign xfer_c = data_valid && data_ready;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      hold_q     <= '0;
      rem_q      <= '0;
      sym_q      <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      TX         <= '0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      state      <= state_d;
      len_q      <= len_d;
      hold_q     <= hold_d;
      rem_q      <= rem_d;
      sym_q      <= sym_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      TX         <= tx_d;
      tx_en      <= tx_en_d;
      busy       <= busy_d;
      done       <= done_d;
      underrun   <= underrun_d;
      data_ready <= ready_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    len_d      = len_q;
    hold_d     = hold_q;
    rem_d      = rem_q;
    sym_d      = sym_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tx_d       = TX;
    tx_en_d    = tx_en;
    busy_d     = busy;
    done_d     = 1'b0;
    underrun_d = underrun;
    ready_d    = 1'b0;

    if (xfer_c && (rem_q != '0)) rem_d = rem_q - CNT_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          underrun_d = 1'b0;
          if (n_bytes == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = (symbol_len == '0) ? LEN_W'(1) : symbol_len;
            rem_d   = n_bytes;
            busy_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer_c) begin
          shift_d = data_in[5:0];
          tx_d    = data_in[7:6];
          tx_en_d = 1'b1;
          hold_d  = len_q - LEN_W'(1);
          sym_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer_c) begin
          buf_d      = data_in;
          buf_full_d = 1'b1;
        end
        if (hold_q != '0) begin
          hold_d = hold_q - LEN_W'(1);
        end else if (sym_q != 2'd3) begin
          tx_d    = shift_q[5:4];
          shift_d = {shift_q[3:0], 2'b00};
          sym_d   = sym_q + 2'd1;
          hold_d  = len_q - LEN_W'(1);
        end else if (buf_full_q) begin
          tx_d       = buf_q[7:6];
          shift_d    = buf_q[5:0];
          buf_full_d = 1'b0;
          sym_d      = 2'd0;
          hold_d     = len_q - LEN_W'(1);
        end else if (xfer_c) begin
          // Byte arriving on the last symbol edge bypasses the buffer
          tx_d       = data_in[7:6];
          shift_d    = data_in[5:0];
          buf_full_d = 1'b0;
          sym_d      = 2'd0;
          hold_d     = len_q - LEN_W'(1);
        end else if (rem_q != '0) begin
          underrun_d = 1'b1;
          tx_d       = 2'b00;
          tx_en_d    = 1'b0;
          state_d    = LOAD;
        end else begin
          tx_d    = 2'b00;
          tx_en_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d != IDLE) && (rem_d != '0) && !buf_full_d;

    // Abort overrides everything except reset; underrun is left as is
    if (abort) begin
      state_d    = IDLE;
      rem_d      = '0;
      buf_full_d = 1'b0;
      tx_d       = 2'b00;
      tx_en_d    = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      ready_d    = 1'b0;
      underrun_d = underrun;
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_sequencer.sv
// Directed self-checking bench for qpsk_symbol_sequencer.
module tb_qpsk_symbol_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] symbol_len;
  logic [7:0]  n_bytes;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [1:0]  TX;
  logic        tx_en;
  logic        busy;
  logic        done;
  logic        underrun;

  int checks;
  int errors;
  logic [7:0] q[$];
  logic       feed_en;

  qpsk_symbol_sequencer #(.LEN_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .symbol_len (symbol_len),
    .n_bytes    (n_bytes),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .TX         (TX),
    .tx_en      (tx_en),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic refresh();
    data_valid = feed_en && (q.size() > 0);
    data_in    = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    logic hs;
    hs = data_valid && data_ready;
    @(posedge clk);
    #1;
    if (hs) void'(q.pop_front());
    refresh();
  endtask

  task automatic start_burst(input logic [15:0] len, input logic [7:0] n);
    symbol_len = len;
    n_bytes    = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, underrun, data_ready, tx_en, TX} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0000000", {busy, done, underrun, data_ready, tx_en, TX});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    logic [1:0] exp_s [4];
    exp_s = '{2'b10, 2'b11, 2'b01, 2'b00};
    q.delete(); q.push_back(8'hB4); feed_en = 1'b1; refresh();
    start_burst(16'd3, 8'd1);
    checks++;
    if ({busy, done, underrun, data_ready, tx_en, TX} !== 7'b1001000) begin
      errors++;
      $display("FAIL single_after_start: got %b want 1001000", {busy, done, underrun, data_ready, tx_en, TX});
    end
    tick();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({done, tx_en, TX} !== {1'b0, 1'b1, exp_s[i/3]}) begin
        errors++;
        $display("FAIL single_sym%0d: got %b want %b", i, {done, tx_en, TX}, {1'b0, 1'b1, exp_s[i/3]});
      end
      tick();
    end
    checks++;
    if ({busy, done, underrun, tx_en, TX} !== 6'b010000) begin
      errors++;
      $display("FAIL single_done: got %b want 010000", {busy, done, underrun, tx_en, TX});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_s [12];
    exp_s = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00,
              2'b11, 2'b11, 2'b11, 2'b11};
    q.delete(); q.push_back(8'h1B); q.push_back(8'hE4); q.push_back(8'hFF); refresh();
    start_burst(16'd2, 8'd3);
    tick();
    for (int i = 0; i < 24; i++) begin
      checks++;
      if ({done, tx_en, TX} !== {1'b0, 1'b1, exp_s[i/2]}) begin
        errors++;
        $display("FAIL seamless_sym%0d: got %b want %b", i, {done, tx_en, TX}, {1'b0, 1'b1, exp_s[i/2]});
      end
      tick();
    end
    checks++;
    if ({busy, done, tx_en, TX, q.size() == 0} !== 6'b010001) begin
      errors++;
      $display("FAIL seamless_end: got %b want 010001", {busy, done, tx_en, TX, q.size() == 0});
    end
    tick();
  endtask

  task automatic test_underrun();
    logic [1:0] exp_a [4];
    logic [1:0] exp_b [4];
    exp_a = '{2'b01, 2'b10, 2'b11, 2'b00};
    exp_b = '{2'b10, 2'b01, 2'b00, 2'b11};
    q.delete(); q.push_back(8'h6C); refresh();
    start_burst(16'd1, 8'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({underrun, tx_en, TX} !== {1'b0, 1'b1, exp_a[i]}) begin
        errors++;
        $display("FAIL underrun_first%0d: got %b want %b", i, {underrun, tx_en, TX}, {1'b0, 1'b1, exp_a[i]});
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({busy, underrun, data_ready, tx_en, TX} !== 6'b111000) begin
        errors++;
        $display("FAIL underrun_gap%0d: got %b want 111000", i, {busy, underrun, data_ready, tx_en, TX});
      end
      tick();
    end
    q.push_back(8'h93); refresh();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx_en, TX} !== {1'b1, exp_b[i]}) begin
        errors++;
        $display("FAIL underrun_second%0d: got %b want %b", i, {tx_en, TX}, {1'b1, exp_b[i]});
      end
      tick();
    end
    checks++;
    if ({busy, done, underrun, tx_en} !== 4'b0110) begin
      errors++;
      $display("FAIL underrun_done: got %b want 0110", {busy, done, underrun, tx_en});
    end
    tick();
    start_burst(16'd1, 8'd0);
    checks++;
    if ({done, underrun} !== 2'b10) begin
      errors++;
      $display("FAIL underrun_clear: got %b want 10", {done, underrun});
    end
    tick();
  endtask

  task automatic test_len_zero();
    logic [1:0] exp_s [4];
    exp_s = '{2'b00, 2'b10, 2'b01, 2'b11};
    q.delete(); q.push_back(8'h27); refresh();
    start_burst(16'd0, 8'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx_en, TX} !== {1'b1, exp_s[i]}) begin
        errors++;
        $display("FAIL len0_sym%0d: got %b want %b", i, {tx_en, TX}, {1'b1, exp_s[i]});
      end
      tick();
    end
    checks++;
    if ({busy, done, tx_en} !== 3'b010) begin
      errors++;
      $display("FAIL len0_done: got %b want 010", {busy, done, tx_en});
    end
    tick();
  endtask

  task automatic test_zero_bytes();
    q.delete(); q.push_back(8'hAA); refresh();
    start_burst(16'd3, 8'd0);
    checks++;
    if ({busy, done, data_ready, tx_en} !== 4'b0100) begin
      errors++;
      $display("FAIL zero_done: got %b want 0100", {busy, done, data_ready, tx_en});
    end
    tick();
    checks++;
    if ({busy, done, data_ready, tx_en, q.size() == 1} !== 5'b00001) begin
      errors++;
      $display("FAIL zero_after: got %b want 00001", {busy, done, data_ready, tx_en, q.size() == 1});
    end
    q.delete(); refresh();
  endtask

  task automatic test_abort();
    logic [1:0] exp_s [4];
    exp_s = '{2'b11, 2'b00, 2'b01, 2'b10};
    q.delete();
    q.push_back(8'h4E); q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); refresh();
    start_burst(16'd2, 8'd4);
    tick();
    tick();
    tick();
    checks++;
    if ({tx_en, TX} !== 3'b100) begin
      errors++;
      $display("FAIL abort_pre: got %b want 100", {tx_en, TX});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, done, data_ready, tx_en, TX} !== 6'b0) begin
      errors++;
      $display("FAIL abort_state: got %b want 000000", {busy, done, data_ready, tx_en, TX});
    end
    tick();
    checks++;
    if ({busy, done, tx_en} !== 3'b0) begin
      errors++;
      $display("FAIL abort_no_done: got %b want 000", {busy, done, tx_en});
    end
    q.delete(); q.push_back(8'hC6); refresh();
    start_burst(16'd1, 8'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx_en, TX} !== {1'b1, exp_s[i]}) begin
        errors++;
        $display("FAIL abort_restart%0d: got %b want %b", i, {tx_en, TX}, {1'b1, exp_s[i]});
      end
      tick();
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL abort_restart_done: got %b want 01", {busy, done});
    end
    tick();
  endtask

  task automatic test_async_reset();
    q.delete(); q.push_back(8'hFF); q.push_back(8'hFF); refresh();
    start_burst(16'd4, 8'd2);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, underrun, data_ready, tx_en, TX} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0000000", {busy, done, underrun, data_ready, tx_en, TX});
    end
    #2;
    rst_n = 1'b1;
    q.delete(); refresh();
    tick();
    tick();
    checks++;
    if ({busy, done, data_ready, tx_en, TX} !== 6'b0) begin
      errors++;
      $display("FAIL async_recover: got %b want 000000", {busy, done, data_ready, tx_en, TX});
    end
  endtask

  task automatic test_ignored_start();
    logic [1:0] exp_s [8];
    exp_s = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01};
    q.delete(); q.push_back(8'hD8); q.push_back(8'h39); refresh();
    start_burst(16'd1, 8'd2);
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({tx_en, TX} !== {1'b1, exp_s[i]}) begin
        errors++;
        $display("FAIL ignored_start_sym%0d: got %b want %b", i, {tx_en, TX}, {1'b1, exp_s[i]});
      end
      if (i == 1) begin
        start = 1'b1; n_bytes = 8'd7; symbol_len = 16'd5;
      end
      tick();
      start = 1'b0;
    end
    checks++;
    if ({busy, done, tx_en} !== 3'b010) begin
      errors++;
      $display("FAIL ignored_start_done: got %b want 010", {busy, done, tx_en});
    end
    tick();
    checks++;
    if ({busy, done, data_ready, tx_en} !== 4'b0) begin
      errors++;
      $display("FAIL ignored_start_idle: got %b want 0000", {busy, done, data_ready, tx_en});
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    symbol_len = 16'd0;
    n_bytes    = 8'd0;
    feed_en    = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_len_zero();
    test_zero_bytes();
    test_abort();
    test_async_reset();
    test_ignored_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
